router_fsm: RTL and testbench

//  Control FSM of the 1x3 packet router; sits between the input register block and three output FIFOs.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_port_sel.sv | 38 +++
 rtl/router_fsm.sv | 128 ++++++++++++
 tb/tb_router_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared state encoding and destination-address constants for the 1x3 router control path.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_0       = 2'd0;
    localparam logic [1:0] ADDR_1       = 2'd1;
    localparam logic [1:0] ADDR_2       = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_port_sel.sv
// Selects the per-port FIFO empty and soft-reset flags for the packet's destination.
// While decoding, the empty flag follows the live header address instead of the latched one.
module router_port_sel
    import router_pkg::*;
(
    input  logic       in_decode_i,
    input  logic [1:0] data_in_i,
    input  logic [1:0] addr_i,
    input  logic [2:0] fifo_empty_i,
    input  logic [2:0] soft_reset_i,
    output logic       empty_sel_o,
    output logic       soft_sel_o
);

    logic [1:0] empty_idx;

    always_comb begin
        empty_idx = in_decode_i ? data_in_i : addr_i;
        empty_sel_o = 1'b0;
        case (empty_idx)
            ADDR_0:  empty_sel_o = fifo_empty_i[0];
            ADDR_1:  empty_sel_o = fifo_empty_i[1];
            ADDR_2:  empty_sel_o = fifo_empty_i[2];
            default: empty_sel_o = 1'b0;
        endcase
    end

    always_comb begin
        soft_sel_o = 1'b0;
        case (addr_i)
            ADDR_0:  soft_sel_o = soft_reset_i[0];
            ADDR_1:  soft_sel_o = soft_reset_i[1];
            ADDR_2:  soft_sel_o = soft_reset_i[2];
            default: soft_sel_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: header decode, payload/parity load, FIFO-full stall.
// Soft-reset abort is enabled by defining FSM_SOFT_RESET_EN; otherwise soft_reset_0/1/2 are ignored.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t     present_state;
    state_t     next_state;
    logic [1:0] addr;
    logic       empty_sel;
    logic       soft_sel;
    logic [2:0] soft_vec;

    logic detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q, write_enb_q, busy_q;

`ifdef FSM_SOFT_RESET_EN
    assign soft_vec = {soft_reset_2, soft_reset_1, soft_reset_0};
`else
    logic unused_soft_reset;
    assign unused_soft_reset = ^{soft_reset_2, soft_reset_1, soft_reset_0, soft_sel};
    assign soft_vec = 3'b000;
`endif

    router_port_sel u_port_sel (
        .in_decode_i  (present_state == DECODE_ADDRESS),
        .data_in_i    (data_in),
        .addr_i       (addr),
        .fifo_empty_i ({fifo_empty_2, fifo_empty_1, fifo_empty_0}),
        .soft_reset_i (soft_vec),
        .empty_sel_o  (empty_sel),
        .soft_sel_o   (soft_sel)
    );

    always_comb begin
        next_state = present_state;
        case (present_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != ADDR_INVALID))
                    next_state = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
`ifdef FSM_SOFT_RESET_EN
        // A read timeout on the destination port aborts whatever the packet was doing.
        if ((present_state != DECODE_ADDRESS) && soft_sel)
            next_state = DECODE_ADDRESS;
`endif
    end

    // Flags are registered from next_state so they line up with present_state without extra delay.
    always_ff @(posedge clock) begin
        if (resetn) begin
            present_state <= DECODE_ADDRESS;
            addr          <= ADDR_0;
            detect_add_q  <= 1'b1;
            lfd_q         <= 1'b0;
            ld_q          <= 1'b0;
            laf_q         <= 1'b0;
            full_q        <= 1'b0;
            rst_int_q     <= 1'b0;
            write_enb_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            present_state <= next_state;
            if ((present_state == DECODE_ADDRESS) && pkt_valid)
                addr <= data_in;
            detect_add_q <= (next_state == DECODE_ADDRESS);
            lfd_q        <= (next_state == LOAD_FIRST_DATA);
            ld_q         <= (next_state == LOAD_DATA);
            laf_q        <= (next_state == LOAD_AFTER_FULL);
            full_q       <= (next_state == FIFO_FULL_STATE);
            rst_int_q    <= (next_state == CHECK_PARITY_ERROR);
            write_enb_q  <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY)
                         || (next_state == LOAD_AFTER_FULL);
            busy_q       <= (next_state != DECODE_ADDRESS) && (next_state != LOAD_DATA);
        end
    end

    assign detect_add    = detect_add_q;
    assign lfd_state     = lfd_q;
    assign ld_state      = ld_q;
    assign laf_state     = laf_q;
    assign full_state    = full_q;
    assign rst_int_reg   = rst_int_q;
    assign write_enb_reg = write_enb_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm: the driver queues expected state/flags per cycle,
// a negedge monitor pops and compares against present_state and all output strobes.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
    logic       full_state, rst_int_reg, busy;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .lfd_state     (lfd_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    // clock / reset
    always #5 clock = ~clock;

    // {state, detect_add, lfd, ld, laf, full, rst_int, write_enb, busy} for a given state
    function automatic logic [10:0] exp_vec(input logic [2:0] st);
        logic [7:0] f;
        case (st)
            3'd0:    f = 8'b1000_0000;
            3'd1:    f = 8'b0100_0001;
            3'd2:    f = 8'b0010_0010;
            3'd3:    f = 8'b0000_0011;
            3'd4:    f = 8'b0000_1001;
            3'd5:    f = 8'b0001_0011;
            3'd6:    f = 8'b0000_0001;
            default: f = 8'b0000_0101;
        endcase
        return {st, f};
    endfunction

    // driver: apply inputs for the next edge, then queue the state expected after it
    task automatic step(input logic rst, input logic pv, input logic [1:0] din,
                        input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                        input logic pd, input logic lpv, input logic [2:0] st,
                        input string nm);
        @(negedge clock);
        resetn        = rst;
        pkt_valid     = pv;
        data_in       = din;
        fifo_full     = ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
        {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
        parity_done   = pd;
        low_pkt_valid = lpv;
        @(posedge clock);
        exp_q.push_back(exp_vec(st));
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [10:0] act;
        logic [10:0] exp;
        string       nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {dut.present_state, detect_add, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_enb_reg, busy};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got state=%0d flags=%b, expected state=%0d flags=%b",
                         nm, act[10:8], act[7:0], exp[10:8], exp[7:0]);
            end
        end
    end

    initial begin
        // reset
        step(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, 3'd0, "reset");
        // idle
        for (int i = 0; i < 4; i++)
            step(0, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, 3'd0, "idle");
        // address 2 full packet
        step(0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd1, "a2_lfd");
        step(0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd2, "a2_ld");
        step(0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd2, "a2_ld_hold");
        step(0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd3, "a2_lp");
        step(0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd7, "a2_cpe");
        step(0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd0, "a2_done");
        // soft reset on port 2 while held
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd1, "sr_lfd");
`ifdef FSM_SOFT_RESET_EN
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd0, "sr_abort");
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd1, "sr_lfd2");
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd0, "sr_abort2");
`else
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd2, "sr_ignored_ld");
        step(0, 1, 2'd2, 0, 3'b100, 3'b100, 0, 0, 3'd2, "sr_ignored_hold");
`endif
        // reset mid-packet aborts back to decode
        step(1, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, 3'd0, "mid_reset");
        // full stall on port 0
        step(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, 3'd1, "f_lfd");
        step(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, 3'd2, "f_ld");
        step(0, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, 3'd4, "f_ffs");
        step(0, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, 3'd4, "f_ffs_hold");
        step(0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 1, 3'd5, "f_laf");
        step(0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 1, 3'd3, "f_laf_to_lp");
        step(0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, 3'd7, "f_cpe");
        step(0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, 3'd4, "f_cpe_full");
        step(0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, 3'd5, "f_laf2");
        step(0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, 3'd2, "f_laf_to_ld");
        step(0, 1, 2'd0, 1, 3'b001, 3'b000, 0, 0, 3'd4, "f_ffs2");
        step(0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, 3'd5, "f_laf3");
        step(0, 0, 2'd0, 0, 3'b001, 3'b000, 1, 1, 3'd0, "f_parity_done");
        // busy destination on port 1
        step(0, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, 3'd6, "b_wte");
        step(0, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, 3'd6, "b_wte_hold");
        step(0, 1, 2'd0, 0, 3'b011, 3'b000, 0, 0, 3'd1, "b_lfd");
        step(0, 1, 2'd0, 0, 3'b011, 3'b000, 0, 0, 3'd2, "b_ld");
        step(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, 3'd0, "b_reset");
        // invalid address
        step(0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, 3'd0, "inv_stay");
        step(0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, 3'd0, "inv_stay2");
        // drain
        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
